// File: rtl/es_pkg.sv
// Shared constants and helpers for the E/S port responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package es_pkg;

   typedef logic [7:0] es_word_t;

   localparam logic [1:0] ES_STATUS_ID = 2'd3;
   localparam int         ES_FULL_LSB  = 1;
   localparam int         ES_OVF_LSB   = 5;
   localparam int         ES_NOUT      = 4;
   localparam int         ES_NIN       = 3;

   // Status word seen by the CPU on input port 3: ovf at [7:5], full at [3:1].
   function automatic es_word_t es_status(input logic [ES_NIN-1:0] ovf,
                                          input logic [ES_NIN-1:0] full);
      es_word_t w;
      w = '0;
      w[ES_OVF_LSB  +: ES_NIN] = ovf;
      w[ES_FULL_LSB +: ES_NIN] = full;
      return w;
   endfunction

endpackage

// File: rtl/es_inport.sv
// One buffered input port: capture register plus full and sticky overrun flags.
// Latency: captured word and flags visible one cycle after stb.
// Backpressure: none; a capture into a full, unread port overwrites and sets ovf.
module es_inport
   import es_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stb,
   input  logic [DW-1:0] din,
   input  logic          rd,
   input  logic          clr_ovf,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          ovf
);

   logic [DW-1:0] data_q, data_d;
   logic          full_q, full_d;
   logic          ovf_q,  ovf_d;

   // Next state: capture beats read for full; overrun set beats status-read clear.
   always_comb begin
      data_d = data_q;
      full_d = full_q;
      ovf_d  = ovf_q;
      if (rd)      full_d = 1'b0;
      if (clr_ovf) ovf_d  = 1'b0;
      if (stb) begin
         data_d = din;
         full_d = 1'b1;
         // A word arriving in the same cycle the CPU drains the old one is no loss.
         if (full_q && !rd) ovf_d = 1'b1;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
         full_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         full_q <= full_d;
         ovf_q  <= ovf_d;
      end
   end

   assign dout = data_q;
   assign full = full_q;
   assign ovf  = ovf_q;

endmodule

// File: rtl/es_ports.sv
// CPU-facing E/S responder: four latched output ports, three buffered input ports, status on port 3.
// Latency: output write 1 cycle; data_in is combinational (0 cycles).
// Backpressure: none; peripherals poll in_full or accept overwrite.
module es_ports
   import es_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we_out,
   input  logic                 s_out,
   input  logic [1:0]           id_out,
   input  logic [DW-1:0]        data_reg,
   input  logic [DW-1:0]        data_mem,
   input  logic                 rd_in,
   input  logic [1:0]           id_in,
   output logic [DW-1:0]        data_in,
   output logic [ES_NOUT*DW-1:0] out_ports,
   output logic [ES_NOUT-1:0]   out_stb,
   input  logic [ES_NIN*DW-1:0] in_ports,
   input  logic [ES_NIN-1:0]    in_stb,
   output logic [ES_NIN-1:0]    in_full,
   output logic [ES_NIN-1:0]    in_ovf
);

   logic [DW-1:0] wr_dat;
   logic [DW-1:0] cap [ES_NIN];
   logic          clr_ovf;

   assign wr_dat  = s_out ? data_mem : data_reg;
   assign clr_ovf = rd_in && (id_in == ES_STATUS_ID);

   for (genvar k = 0; k < ES_NOUT; k++) begin : g_out
      logic [DW-1:0] port_q, port_d;
      logic          stb_q, stb_d;
      logic          hit;

      assign hit = we_out && (id_out == 2'(k));

      // Load the selected port; the strobe is just the registered hit.
      always_comb begin
         port_d = port_q;
         stb_d  = hit;
         if (hit) port_d = wr_dat;
      end

      // Output port register and its update strobe.
      always_ff @(posedge clk) begin
         if (reset) begin
            port_q <= '0;
            stb_q  <= 1'b0;
         end else begin
            port_q <= port_d;
            stb_q  <= stb_d;
         end
      end

      assign out_ports[k*DW +: DW] = port_q;
      assign out_stb[k]            = stb_q;
   end

   for (genvar k = 0; k < ES_NIN; k++) begin : g_in
      es_inport #(.DW(DW)) u_inport (
         .clk     (clk),
         .reset   (reset),
         .stb     (in_stb[k]),
         .din     (in_ports[k*DW +: DW]),
         .rd      (rd_in && (id_in == 2'(k))),
         .clr_ovf (clr_ovf),
         .dout    (cap[k]),
         .full    (in_full[k]),
         .ovf     (in_ovf[k])
      );
   end

   // Read mux: capture register for ports 0..2, status word otherwise; independent of rd_in.
   always_comb begin
      data_in = es_status(in_ovf, in_full);
      for (int k = 0; k < ES_NIN; k++) begin
         if (id_in == 2'(k)) data_in = cap[k];
      end
   end

endmodule

// File: tb/tb_es_ports.sv
module tb_es_ports;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        we_out = 1'b0, s_out = 1'b0;
   logic [1:0]  id_out = '0;
   logic [7:0]  data_reg = '0, data_mem = '0;
   logic        rd_in = 1'b0;
   logic [1:0]  id_in = '0;
   logic [7:0]  data_in;
   logic [31:0] out_ports;
   logic [3:0]  out_stb;
   logic [23:0] in_ports = '0;
   logic [2:0]  in_stb = '0;
   logic [2:0]  in_full, in_ovf;

   es_ports #(.DW(8)) dut (
      .clk(clk), .reset(reset), .we_out(we_out), .s_out(s_out), .id_out(id_out),
      .data_reg(data_reg), .data_mem(data_mem), .rd_in(rd_in), .id_in(id_in),
      .data_in(data_in), .out_ports(out_ports), .out_stb(out_stb),
      .in_ports(in_ports), .in_stb(in_stb), .in_full(in_full), .in_ovf(in_ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] op;
      logic [3:0]  stb;
      logic [2:0]  full;
      logic [2:0]  ovf;
      logic [7:0]  din;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model: plain per-port arrays updated from the behavioural rules.
   logic [7:0] out_m [4];
   logic [7:0] cap_m [3];
   logic [3:0] stb_m;
   logic [2:0] full_m, ovf_m;
   bit         known = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: the DUT presents its outputs every cycle; compare mid-cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         cmp("out_ports", out_ports, e.op);
         cmp("out_stb",   {28'd0, out_stb}, {28'd0, e.stb});
         cmp("in_full",   {29'd0, in_full}, {29'd0, e.full});
         cmp("in_ovf",    {29'd0, in_ovf},  {29'd0, e.ovf});
         cmp("data_in",   {24'd0, data_in}, {24'd0, e.din});
      end
   end

   task automatic step(input logic rst, input logic we, input logic s, input logic [1:0] ido,
                       input logic [7:0] dreg, input logic [7:0] dmem,
                       input logic rd, input logic [1:0] idi,
                       input logic [23:0] inp, input logic [2:0] istb);
      exp_t e;
      logic [2:0] nfull, novf;
      reset = rst; we_out = we; s_out = s; id_out = ido;
      data_reg = dreg; data_mem = dmem; rd_in = rd; id_in = idi;
      in_ports = inp; in_stb = istb;
      if (known) begin
         e.op   = {out_m[3], out_m[2], out_m[1], out_m[0]};
         e.stb  = stb_m;
         e.full = full_m;
         e.ovf  = ovf_m;
         e.din  = (idi == 2'd3) ? {ovf_m, 1'b0, full_m, 1'b0} : cap_m[idi];
         q.push_back(e);
      end
      if (rst) begin
         for (int k = 0; k < 4; k++) out_m[k] = 8'h00;
         for (int k = 0; k < 3; k++) cap_m[k] = 8'h00;
         stb_m = '0; full_m = '0; ovf_m = '0;
         known = 1;
      end else begin
         stb_m = '0;
         if (we) begin
            out_m[ido] = s ? dmem : dreg;
            stb_m[ido] = 1'b1;
         end
         nfull = full_m;
         novf  = (rd && idi == 2'd3) ? 3'b000 : ovf_m;
         for (int k = 0; k < 3; k++) begin
            if (rd && idi == k) nfull[k] = 1'b0;
            if (istb[k]) begin
               if (full_m[k] && !(rd && idi == k)) novf[k] = 1'b1;
               nfull[k] = 1'b1;
               cap_m[k] = inp[8*k +: 8];
            end
         end
         full_m = nfull;
         ovf_m  = novf;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [1:0] idi);
      step(0, 0, 0, 2'd0, 8'h00, 8'h00, 0, idi, 24'h0, 3'b000);
   endtask

   initial begin
      @(posedge clk);
      #1;
      // Reset with everything else asserted; reset must dominate.
      step(1, 1, 1, 2'd1, 8'hFF, 8'hEE, 0, 2'd0, 24'hABCDEF, 3'b111);
      step(1, 1, 0, 2'd2, 8'hFF, 8'hEE, 1, 2'd3, 24'h123456, 3'b111);
      idle(2'd3);
      // Output writes: immediate to port 2, then register to port 0.
      step(0, 1, 1, 2'd2, 8'h00, 8'hA5, 0, 2'd0, 24'h0, 3'b000);
      idle(2'd0);
      step(0, 1, 0, 2'd0, 8'h3C, 8'h00, 0, 2'd0, 24'h0, 3'b000);
      idle(2'd0);
      // Back-to-back writes to one port.
      step(0, 1, 0, 2'd3, 8'h01, 8'h00, 0, 2'd0, 24'h0, 3'b000);
      step(0, 1, 1, 2'd3, 8'h00, 8'h02, 0, 2'd0, 24'h0, 3'b000);
      idle(2'd0);
      // Capture on port 1 then read it.
      step(0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 24'h005A00, 3'b010);
      step(0, 0, 0, 2'd0, 8'h00, 8'h00, 1, 2'd1, 24'h0, 3'b000);
      idle(2'd1);
      // Overrun on port 0, status read, flags afterwards.
      step(0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 24'h000011, 3'b001);
      step(0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 24'h000022, 3'b001);
      idle(2'd0);
      step(0, 0, 0, 2'd0, 8'h00, 8'h00, 1, 2'd3, 24'h0, 3'b000);
      idle(2'd3);
      // Read and capture on port 2 in the same cycle.
      step(0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 24'h770000, 3'b100);
      step(0, 0, 0, 2'd0, 8'h00, 8'h00, 1, 2'd2, 24'h880000, 3'b100);
      idle(2'd2);
      // Status read colliding with an overrun on port 1; port 0 ovf must clear.
      step(0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 24'h000033, 3'b001);
      step(0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 24'h004400, 3'b010);
      step(0, 0, 0, 2'd0, 8'h00, 8'h00, 1, 2'd3, 24'h005500, 3'b010);
      idle(2'd3);
      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 60) == 0), 1'($urandom), 1'($urandom), 2'($urandom),
              8'($urandom), 8'($urandom), 1'($urandom_range(0, 2) == 0), 2'($urandom),
              24'($urandom), 3'($urandom) & 3'($urandom));
      end
      idle(2'd3);
      begin
         int budget;
         budget = 0;
         while (q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
         end
         if (q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expected records left, required 0", q.size());
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
